fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_e;

   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP              = 32'h0000_0013;
   localparam int unsigned INSTR_WIDTH      = 32;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush that buffers fetched {Instr, PC, PCPlus4} toward decode.
// Push and pop may coincide, including at full.
module fetch_fifo #(
   parameter int WIDTH = 96,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_data,
   output logic [$clog2(DEPTH):0] o_count,
   output logic                   o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;
   logic             w_full;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_empty   = (r_count == '0);
   assign w_full    = (r_count == CW'(DEPTH));
   assign w_do_pop  = i_pop & ~o_empty & ~i_flush;
   assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n || i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
      end
   end

   // NOTE: storage is not reset; only pointers and count need a defined value, the head is qualified by o_empty.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the fetch PC, drives a synchronous instruction memory,
// resolves taken branches/jumps and buffers fetched instructions toward decode.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(DEFAULT_RESET_PC),
   parameter int                    FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  Branch,
   input  logic                  Jump,
   input  logic [2:0]            funct3,
   input  logic                  Zero,
   input  logic [DATA_WIDTH-1:0] PCTarget,
   input  logic                  halt,
   output logic                  imem_en,
   output logic [DATA_WIDTH-1:0] imem_addr,
   input  logic [31:0]           imem_rdata,
   output logic                  instr_valid,
   input  logic                  instr_ready,
   output logic [31:0]           Instr,
   output logic [DATA_WIDTH-1:0] PC,
   output logic [DATA_WIDTH-1:0] PCPlus4,
   output logic                  misalign_err
);
   localparam int PAYLOAD_W = INSTR_WIDTH + 2 * DATA_WIDTH;
   localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;
   localparam int OCC_W     = CNT_W + 1;
   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   fetch_state_e          r_state;
   fetch_state_e          w_state_next;
   logic [DATA_WIDTH-1:0] r_fetch_pc;
   logic [DATA_WIDTH-1:0] r_resp_pc;
   logic                  r_inflight;
   logic                  r_misalign_err;
   logic                  w_taken;
   logic                  w_redirect;
   logic                  w_target_misaligned;
   logic                  w_bad_redirect;
   logic                  w_issue;
   logic                  w_push;
   logic                  w_pop;
   logic                  w_room;
   logic                  w_empty;
   logic                  w_unused;
   logic [OCC_W-1:0]      w_occ_next;
   logic [CNT_W-1:0]      w_count;
   logic [PAYLOAD_W-1:0]  w_push_data;
   logic [PAYLOAD_W-1:0]  w_head;

   // Zero is from SUB (BEQ/BNE) or SLT/SLTU (ordered compares); funct3[2]^funct3[0] flips the sense.
   // funct3[1] (signed vs unsigned) is already folded into Zero by the datapath.
   assign w_taken             = Jump | (Branch & (Zero ^ funct3[2] ^ funct3[0]));
   assign w_unused            = funct3[1];
   assign w_redirect          = w_taken;
   assign w_target_misaligned = |PCTarget[1:0];
   assign w_bad_redirect      = w_redirect & w_target_misaligned;

   assign w_pop  = instr_valid & instr_ready & ~w_redirect;
   assign w_push = r_inflight & ~w_redirect;

   // Occupancy once this cycle's response lands and any pop completes; a request issued now lands next cycle.
   assign w_occ_next = OCC_W'(w_count) + OCC_W'(r_inflight) - OCC_W'(w_pop);
   assign w_room     = (w_occ_next < OCC_W'(FIFO_DEPTH));
   assign w_issue    = (r_state == RUN) & w_room & ~w_redirect & ~halt;

   assign imem_en   = w_issue;
   assign imem_addr = r_fetch_pc;

   // NOTE: next-state is defaulted before the case so no path leaves it unassigned and infers a latch.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         BOOT: w_state_next = RUN;
         RUN: begin
            if (halt || w_bad_redirect) w_state_next = HALT;
         end
         HALT: begin
            if (!halt && !r_misalign_err && !w_bad_redirect) w_state_next = RUN;
         end
         default: w_state_next = BOOT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state        <= BOOT;
         r_fetch_pc     <= RESET_PC;
         r_resp_pc      <= '0;
         r_inflight     <= 1'b0;
         r_misalign_err <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_inflight <= w_issue;
         if (w_issue) r_resp_pc <= r_fetch_pc;
         if (w_redirect) begin
            if (w_target_misaligned) r_misalign_err <= 1'b1;
            else                     r_fetch_pc     <= PCTarget;
         end else if (w_issue) begin
            r_fetch_pc <= r_fetch_pc + PC_STEP;
         end
      end
   end

   assign w_push_data = {imem_rdata, r_resp_pc, r_resp_pc + PC_STEP};

   fetch_fifo #(
      .WIDTH (PAYLOAD_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_flush (w_redirect),
      .i_push  (w_push),
      .i_data  (w_push_data),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign instr_valid  = ~w_empty;
   assign Instr        = instr_valid ? w_head[PAYLOAD_W-1 -: INSTR_WIDTH]      : '0;
   assign PC           = instr_valid ? w_head[2*DATA_WIDTH-1 -: DATA_WIDTH]    : '0;
   assign PCPlus4      = instr_valid ? w_head[DATA_WIDTH-1:0]                  : '0;
   assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven branch conditions, hand-written
// corner sequences and a PC scoreboard checked at every decode accept.
module tb_fetch_unit;
   import fetch_pkg::*;

   typedef struct packed {
      logic       br;
      logic       jmp;
      logic [2:0] f3;
      logic       zero;
      logic       taken;
   } br_vec_t;

   logic        clk;
   logic        rst_n;
   logic        Branch;
   logic        Jump;
   logic [2:0]  funct3;
   logic        Zero;
   logic [31:0] PCTarget;
   logic        halt;
   logic        imem_en;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata = NOP;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        misalign_err;

   logic        tb_redir;
   int          total = 0;
   int          bad   = 0;
   int          n_acc = 0;
   int          n_iss = 0;
   int          a0;
   logic [31:0] sb[$];
   br_vec_t     vecs[12];

   fetch_unit #(
      .DATA_WIDTH (32),
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .Branch       (Branch),
      .Jump         (Jump),
      .funct3       (funct3),
      .Zero         (Zero),
      .PCTarget     (PCTarget),
      .halt         (halt),
      .imem_en      (imem_en),
      .imem_addr    (imem_addr),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .Instr        (Instr),
      .PC           (PC),
      .PCPlus4      (PCPlus4),
      .misalign_err (misalign_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // Synchronous instruction memory: data valid the cycle after the request.
   always @(posedge clk) begin
      if (imem_en) imem_rdata <= mem_word(imem_addr);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic sb_load(input logic [31:0] start);
      sb.delete();
      for (int k = 0; k < 200; k++) sb.push_back(start + 32'(4 * k));
   endtask

   // Settle just after the input change, then check any decode accept against the scoreboard.
   task automatic sample();
      logic [31:0] e;
      #1;
      if (imem_en) n_iss++;
      if (rst_n && instr_valid && instr_ready && !tb_redir) begin
         n_acc++;
         check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("acc_pc", PC, e);
            check("acc_instr", Instr, mem_word(e));
            check("acc_pc4", PCPlus4, e + 32'd4);
         end
      end
   endtask

   task automatic next();
      @(negedge clk);
   endtask

   task automatic step();
      sample();
      next();
   endtask

   task automatic clear_ctrl();
      Branch   = 1'b0;
      Jump     = 1'b0;
      funct3   = 3'b000;
      Zero     = 1'b0;
      PCTarget = 32'h0;
      tb_redir = 1'b0;
   endtask

   task automatic do_reset();
      rst_n       = 1'b0;
      halt        = 1'b0;
      instr_ready = 1'b0;
      clear_ctrl();
      step();
      sample();
      check("rst_en", 32'(imem_en), 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      check("rst_instr", Instr, 32'h0);
      check("rst_pc", PC, 32'h0);
      check("rst_pc4", PCPlus4, 32'h0);
      check("rst_misalign", 32'(misalign_err), 32'd0);
      next();
      rst_n = 1'b1;
      sb_load(32'h0);
      n_acc = 0;
      n_iss = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = '{1'b1, 1'b0, 3'b000, 1'b1, 1'b1};  // BEQ equal
      vecs[1]  = '{1'b1, 1'b0, 3'b000, 1'b0, 1'b0};  // BEQ not equal
      vecs[2]  = '{1'b1, 1'b0, 3'b001, 1'b0, 1'b1};  // BNE not equal
      vecs[3]  = '{1'b1, 1'b0, 3'b001, 1'b1, 1'b0};  // BNE equal
      vecs[4]  = '{1'b1, 1'b0, 3'b100, 1'b0, 1'b1};  // BLT less
      vecs[5]  = '{1'b1, 1'b0, 3'b101, 1'b0, 1'b0};  // BGE less
      vecs[6]  = '{1'b1, 1'b0, 3'b101, 1'b1, 1'b1};  // BGE not less
      vecs[7]  = '{1'b1, 1'b0, 3'b110, 1'b1, 1'b0};  // BLTU not less
      vecs[8]  = '{1'b1, 1'b0, 3'b111, 1'b1, 1'b1};  // BGEU not less
      vecs[9]  = '{1'b0, 1'b0, 3'b001, 1'b0, 1'b0};  // not a branch
      vecs[10] = '{1'b0, 1'b1, 3'b000, 1'b0, 1'b1};  // JAL
      vecs[11] = '{1'b1, 1'b1, 3'b000, 1'b0, 1'b1};  // jump dominates failed condition

      rst_n       = 1'b0;
      halt        = 1'b0;
      instr_ready = 1'b0;
      clear_ctrl();
      @(negedge clk);

      // Reset release and streaming
      do_reset();
      instr_ready = 1'b1;
      sample();
      check("boot_en", 32'(imem_en), 32'd0);
      check("boot_valid", 32'(instr_valid), 32'd0);
      next();
      for (int c = 1; c <= 8; c++) begin
         sample();
         check($sformatf("seq_en[%0d]", c), 32'(imem_en), 32'd1);
         check($sformatf("seq_addr[%0d]", c), imem_addr, 32'(4 * (c - 1)));
         check($sformatf("seq_valid[%0d]", c), 32'(instr_valid), 32'(c >= 3));
         if (c == 3) begin
            check("first_pc", PC, 32'h0);
            check("first_pc4", PCPlus4, 32'h4);
         end
         next();
      end
      repeat (4) step();
      check("stream_accepts", 32'(n_acc), 32'd10);

      // Mid-operation reset, then backpressure
      do_reset();
      for (int c = 0; c < 6; c++) step();
      sample();
      check("bp_en_off", 32'(imem_en), 32'd0);
      check("bp_valid", 32'(instr_valid), 32'd1);
      check("bp_issues", 32'(n_iss), 32'd2);
      next();
      instr_ready = 1'b1;
      repeat (12) step();
      check("bp_accepts", 32'(n_acc), 32'd12);

      // BNE taken while the FIFO is full
      instr_ready = 1'b0;
      repeat (3) step();
      sample();
      check("full_valid", 32'(instr_valid), 32'd1);
      next();
      Branch = 1'b1; funct3 = 3'b001; Zero = 1'b0; PCTarget = 32'h100;
      instr_ready = 1'b1; tb_redir = 1'b1;
      sample();
      check("redir_en", 32'(imem_en), 32'd0);
      next();
      clear_ctrl();
      sb_load(32'h100);
      sample();
      check("redir_n1_en", 32'(imem_en), 32'd1);
      check("redir_n1_addr", imem_addr, 32'h100);
      check("redir_n1_valid", 32'(instr_valid), 32'd0);
      next();
      sample();
      check("redir_n2_valid", 32'(instr_valid), 32'd0);
      check("redir_n2_addr", imem_addr, 32'h104);
      next();
      sample();
      check("redir_n3_valid", 32'(instr_valid), 32'd1);
      check("redir_n3_pc", PC, 32'h100);
      next();
      repeat (6) step();

      // Branch-condition table
      for (int i = 0; i < 12; i++) begin
         logic [31:0] tgt;
         tgt = 32'h400 + 32'(i) * 32'h40;
         repeat (4) step();
         Branch   = vecs[i].br;
         Jump     = vecs[i].jmp;
         funct3   = vecs[i].f3;
         Zero     = vecs[i].zero;
         PCTarget = tgt;
         tb_redir = vecs[i].taken;
         sample();
         check($sformatf("br_en[%0d]", i), 32'(imem_en), 32'(!vecs[i].taken));
         next();
         clear_ctrl();
         if (vecs[i].taken) begin
            sb_load(tgt);
            sample();
            check($sformatf("br_target[%0d]", i), imem_addr, tgt);
            next();
         end
      end
      repeat (6) step();

      // Halt: no issues, buffered entries drain, resume at the next sequential PC
      do_reset();
      repeat (5) step();
      halt = 1'b1;
      instr_ready = 1'b1;
      a0 = n_acc;
      for (int h = 0; h < 3; h++) begin
         sample();
         check($sformatf("halt_en[%0d]", h), 32'(imem_en), 32'd0);
         next();
      end
      check("halt_drain", 32'(n_acc - a0), 32'd2);
      halt = 1'b0;
      sample();
      check("unhalt_en0", 32'(imem_en), 32'd0);
      next();
      sample();
      check("resume_en", 32'(imem_en), 32'd1);
      check("resume_addr", imem_addr, 32'h8);
      next();
      repeat (8) step();

      // Misaligned jump: sticky error, HALT, fetch PC kept
      Jump = 1'b1; PCTarget = 32'h800; tb_redir = 1'b1; instr_ready = 1'b0;
      step();
      clear_ctrl();
      sb_load(32'h800);
      repeat (4) step();
      Jump = 1'b1; PCTarget = 32'h102; tb_redir = 1'b1;
      sample();
      check("mis_en", 32'(imem_en), 32'd0);
      next();
      clear_ctrl();
      instr_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
         sample();
         check($sformatf("mis_err[%0d]", k), 32'(misalign_err), 32'd1);
         check($sformatf("mis_en_off[%0d]", k), 32'(imem_en), 32'd0);
         check($sformatf("mis_addr[%0d]", k), imem_addr, 32'h808);
         check($sformatf("mis_valid[%0d]", k), 32'(instr_valid), 32'd0);
         next();
      end
      do_reset();
      instr_ready = 1'b1;
      step();
      sample();
      check("recover_en", 32'(imem_en), 32'd1);
      check("recover_addr", imem_addr, 32'h0);
      next();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
